// File: rtl/pe_acc_if.sv
// Beat input and result output of the 2x2 partial-product accumulator.
// The slave side is the accumulator; the master side drives beats and sinks results.
interface pe_acc_if #(
    parameter int IW = 9,
    parameter int AW = 11
);
    logic          in_val;
    logic [IW-1:0] c11, c12, c21, c22;
    logic          acc_val;
    logic          acc_rdy;
    logic [AW-1:0] d11, d12, d21, d22;
    logic          ovf_err;

    modport master (
        output in_val, c11, c12, c21, c22, acc_rdy,
        input  acc_val, d11, d12, d21, d22, ovf_err
    );

    modport slave (
        input  in_val, c11, c12, c21, c22, acc_rdy,
        output acc_val, d11, d12, d21, d22, ovf_err
    );
endinterface

// File: rtl/pe_acc.sv
// Sums NBLK partial-product beats per 2x2 element.
// Finished results go into a 2-deep first-word-fall-through FIFO; a push into a full FIFO is dropped.
module pe_acc_lane #(
    parameter int IW = 9,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_val,
    input  logic          first,
    input  logic [IW-1:0] c,
    output logic [AW-1:0] sum
);
    logic [AW-1:0] acc;

    // The first beat of a block ignores acc, so acc never needs clearing between blocks.
    assign sum = (first ? '0 : acc) + AW'(c);

    always_ff @(posedge clk) begin
        if (rst)         acc <= '0;
        else if (in_val) acc <= sum;
    end
endmodule

module pe_acc #(
    parameter int IW   = 9,
    parameter int NBLK = 4
) (
    input  logic       clk,
    input  logic       rst,
    pe_acc_if.slave    bus
);
    localparam int AW        = IW + $clog2(NBLK);
    localparam int NUM_LANES = 4;
    localparam int CW        = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef logic [NUM_LANES-1:0][AW-1:0] res_t;

    logic [CW-1:0]                beat_cnt;
    logic                         first, last;
    logic [NUM_LANES-1:0][IW-1:0] c_vec;
    res_t                         sum_vec;

    assign first = (beat_cnt == '0);
    assign last  = (beat_cnt == CW'(NBLK - 1));
    assign c_vec = {bus.c22, bus.c21, bus.c12, bus.c11};

    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_lane
            pe_acc_lane #(.IW(IW), .AW(AW)) u_lane (
                .clk    (clk),
                .rst    (rst),
                .in_val (bus.in_val),
                .first  (first),
                .c      (c_vec[l]),
                .sum    (sum_vec[l])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            beat_cnt <= '0;
        else if (bus.in_val)
            beat_cnt <= last ? '0 : beat_cnt + CW'(1);
    end

    res_t       mem [2];
    res_t       hold;
    logic       rd_ptr, wr_ptr;
    logic [1:0] cnt;
    logic       push, pop, full, wr_en, ovf_q;

    assign push  = bus.in_val & last;
    assign pop   = bus.acc_val & bus.acc_rdy;
    assign full  = (cnt == 2'd2);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sum_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
            hold   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (pop) begin
                hold   <= mem[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, wr_en} - {1'b0, pop};
            if (push & full & ~pop) ovf_q <= 1'b1;
        end
    end

    res_t head;

    // Outputs fall back to the last popped result while the FIFO is empty.
    assign bus.acc_val = (cnt != 2'd0);
    assign head        = bus.acc_val ? mem[rd_ptr] : hold;
    assign bus.d11     = head[0];
    assign bus.d12     = head[1];
    assign bus.d21     = head[2];
    assign bus.d22     = head[3];
    assign bus.ovf_err = ovf_q;
endmodule

// File: tb/tb_pe_acc.sv
// Bench for pe_acc: NBLK=4 and NBLK=1 instances, checked every cycle against a queue model,
// plus table vectors and hand-written FIFO/overflow/reset sequences.
module tb_pe_acc;
    typedef logic [3:0][10:0] res_t;
    typedef struct {
        int b[4][4];
        int e[4];
    } vec_t;

    logic       clk, rst;
    logic       iv  [2];
    logic [8:0] cc  [2][4];
    logic       rdy [2];
    logic       av  [2];
    logic [10:0] dd [2][4];
    logic       ov  [2];

    int total = 0, bad = 0, pops0 = 0;
    int nblk[2] = '{4, 1};
    int bc[2];
    int accm[2][4];
    bit movf[2];
    res_t last_m[2];
    res_t q4[$], q1[$];
    vec_t tbl[3];

    pe_acc_if #(.IW(9), .AW(11)) bus4 ();
    pe_acc_if #(.IW(9), .AW(9))  bus1 ();

    pe_acc #(.IW(9), .NBLK(4)) u4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    pe_acc #(.IW(9), .NBLK(1)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    assign bus4.in_val = iv[0];
    assign bus4.c11 = cc[0][0];
    assign bus4.c12 = cc[0][1];
    assign bus4.c21 = cc[0][2];
    assign bus4.c22 = cc[0][3];
    assign bus4.acc_rdy = rdy[0];
    assign av[0] = bus4.acc_val;
    assign ov[0] = bus4.ovf_err;
    assign dd[0][0] = bus4.d11;
    assign dd[0][1] = bus4.d12;
    assign dd[0][2] = bus4.d21;
    assign dd[0][3] = bus4.d22;

    assign bus1.in_val = iv[1];
    assign bus1.c11 = cc[1][0];
    assign bus1.c12 = cc[1][1];
    assign bus1.c21 = cc[1][2];
    assign bus1.c22 = cc[1][3];
    assign bus1.acc_rdy = rdy[1];
    assign av[1] = bus1.acc_val;
    assign ov[1] = bus1.ovf_err;
    assign dd[1][0] = 11'(bus1.d11);
    assign dd[1][1] = 11'(bus1.d12);
    assign dd[1][2] = 11'(bus1.d21);
    assign dd[1][3] = 11'(bus1.d22);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1);
    end

    function automatic int msize(int d);
        return (d == 0) ? q4.size() : q1.size();
    endfunction

    function automatic res_t mhead(int d);
        return (d == 0) ? q4[0] : q1[0];
    endfunction

    task automatic mpop(int d);
        if (d == 0) void'(q4.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic mpush(int d, res_t r);
        if (d == 0) q4.push_back(r);
        else        q1.push_back(r);
    endtask

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, d, act, exp);
        end
    endtask

    // Steps both models across one clock edge, then compares both DUTs.
    task automatic tick();
        bit   pop_m, push_m, full;
        res_t r, act, exp;
        int   s;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                bc[d] = 0;
                for (int l = 0; l < 4; l++) accm[d][l] = 0;
                if (d == 0) q4.delete(); else q1.delete();
                last_m[d] = '0;
                movf[d] = 1'b0;
            end else begin
                r = '0;
                pop_m = (msize(d) > 0) && rdy[d];
                push_m = 1'b0;
                if (iv[d]) begin
                    for (int l = 0; l < 4; l++) begin
                        s = ((bc[d] == 0) ? 0 : accm[d][l]) + int'(cc[d][l]);
                        accm[d][l] = s;
                        r[l] = 11'(s);
                    end
                    if (bc[d] == nblk[d] - 1) begin
                        push_m = 1'b1;
                        bc[d] = 0;
                    end else bc[d]++;
                end
                full = (msize(d) == 2);
                if (pop_m) begin
                    if (d == 0) pops0++;
                    last_m[d] = mhead(d);
                    mpop(d);
                end
                if (push_m) begin
                    if (full && !pop_m) movf[d] = 1'b1;
                    else                mpush(d, r);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < 4; l++) act[l] = dd[d][l];
            exp = (msize(d) > 0) ? mhead(d) : last_m[d];
            chk("acc_val", d, 64'(av[d]), 64'(msize(d) > 0));
            chk("data", d, 64'(act), 64'(exp));
            chk("ovf_err", d, 64'(ov[d]), 64'(movf[d]));
        end
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0;
            rdy[d] = 1'b0;
            for (int l = 0; l < 4; l++) cc[d][l] = '0;
        end
    endtask

    task automatic beat0(int a0, int a1, int a2, int a3);
        iv[0] = 1'b1;
        cc[0][0] = 9'(a0);
        cc[0][1] = 9'(a1);
        cc[0][2] = 9'(a2);
        cc[0][3] = 9'(a3);
        tick();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            tbl[0].b[k] = '{k + 1, 0, 0, 0};
            tbl[1].b[k] = '{511, 511, 511, 511};
            tbl[2].b[k] = '{0, 100, (k % 2) * 511, (k == 0) ? 7 : 0};
        end
        tbl[0].e = '{10, 0, 0, 0};
        tbl[1].e = '{2044, 2044, 2044, 2044};
        tbl[2].e = '{0, 400, 1022, 7};

        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset acc_val", 0, 64'(av[0]), 64'd0);
        chk("reset d11", 0, 64'(dd[0][0]), 64'd0);
        chk("reset ovf", 0, 64'(ov[0]), 64'd0);
        rst = 1'b0;
        tick();

        // Table vectors: four back-to-back beats, result visible one cycle after the last.
        rdy[0] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 4; k++) begin
                beat0(tbl[t].b[k][0], tbl[t].b[k][1], tbl[t].b[k][2], tbl[t].b[k][3]);
                if (k < 3) chk("early acc_val", 0, 64'(av[0]), 64'd0);
            end
            iv[0] = 1'b0;
            chk("vec acc_val", 0, 64'(av[0]), 64'd1);
            for (int l = 0; l < 4; l++)
                chk("vec data", 0, 64'(dd[0][l]), 64'(tbl[t].e[l]));
            tick();
        end

        // Sink stalled for three results: third is dropped, first two drain in order.
        rdy[0] = 1'b0;
        for (int k = 1; k <= 12; k++) beat0(k, 0, 0, 2 * k);
        iv[0] = 1'b0;
        chk("stall ovf", 0, 64'(ov[0]), 64'd1);
        chk("stall head", 0, 64'(dd[0][0]), 64'd10);
        pops0 = 0;
        rdy[0] = 1'b1;
        repeat (5) tick();
        chk("stall pops", 0, 64'(pops0), 64'd2);

        // Full FIFO with a pop in the completion cycle of the third result: nothing lost.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pops0 = 0;
        for (int k = 1; k <= 12; k++) begin
            rdy[0] = (k == 12);
            beat0(k, 1, 0, 0);
        end
        iv[0] = 1'b0;
        rdy[0] = 1'b1;
        repeat (5) tick();
        chk("full-pop ovf", 0, 64'(ov[0]), 64'd0);
        chk("full-pop pops", 0, 64'(pops0), 64'd3);

        // Reset in the middle of a block discards the partial sum.
        beat0(5, 0, 0, 0);
        beat0(5, 0, 0, 0);
        iv[0] = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid-rst acc_val", 0, 64'(av[0]), 64'd0);
        chk("mid-rst ovf", 0, 64'(ov[0]), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) beat0(1, 0, 0, 0);
        iv[0] = 1'b0;
        chk("mid-rst acc_val", 0, 64'(av[0]), 64'd1);
        chk("mid-rst d11", 0, 64'(dd[0][0]), 64'd4);
        tick();

        // Random gaps and backpressure on both block sizes.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 800; n++) begin
            for (int d = 0; d < 2; d++) begin
                iv[d] = ($urandom_range(0, 9) < 6);
                rdy[d] = ($urandom_range(0, 9) < 6);
                for (int l = 0; l < 4; l++) cc[d][l] = 9'($urandom_range(0, 511));
            end
            tick();
        end
        idle();
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
